peripheral_bcd7seg: RTL and testbench

- Memory-mapped femtoRV peripheral that drives a 5-digit multiplexed 7-segment display.
- Consumes the 20-bit packed-BCD value produced by the binary-to-BCD peripheral. Firmware reads that result and writes it here.
- Handles atomic two-part value loading, per-digit decimal points, optional leading-zero blanking, and time-multiplexed anode scanning with a programmable refresh rate.

---
 rtl/peripheral_bcd7seg.sv | 273 +++++++++++++++++++++++++++
 tb/tb_peripheral_bcd7seg.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bcd7seg.sv
// Purpose : femtoRV bus peripheral that scans a 5-digit multiplexed 7-segment display
//           from a 20-bit packed-BCD value loaded atomically in two writes.
// Latency : register writes/reads complete on the sampling falling edge; an/seg/dp are
//           registered, lagging idx and the display register by one edge.
// Backpr. : none; the bus is strobe based and every access completes in one edge.
//
// Ports:
//   clk    system clock, all state updates on the falling edge
//   reset  asynchronous active-high reset
//   d_in   16-bit write data          cs/addr/rd/wr  bus select, byte address, strobes
//   d_out  32-bit registered read data (holds when not reading a mapped register)
//   an     digit anodes, active-low, an[0] = rightmost digit
//   seg    segments {g,f,e,d,c,b,a}, active-low
//   dp     decimal point, active-low
module peripheral_bcd7seg #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic [4:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // --------------------------------------------------------------------------
  // Register map
  // --------------------------------------------------------------------------
  localparam logic [4:0] ADDR_LO     = 5'h04;
  localparam logic [4:0] ADDR_HI     = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h0C;
  localparam logic [4:0] ADDR_DPM    = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;

  // Terminal prescaler count; CLK_DIV is at most 65535 so 16 bits suffice.
  localparam logic [15:0] PRESC_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  IDX_LAST   = 3'd4;

  // Display-off pattern driven in OFF and for blanked digits.
  localparam logic [4:0] AN_OFF  = 5'b11111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] staging_q;
  logic [19:0] display_q;
  logic        lzb_q;
  logic [4:0]  dpm_q;
  logic [15:0] presc_q;
  logic [2:0]  idx_q;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic wr_en, rd_en;
  logic wr_lo, wr_hi, wr_ctrl, wr_dpm;

  assign wr_en   = cs & wr;
  assign rd_en   = cs & rd;
  assign wr_lo   = wr_en && (addr == ADDR_LO);
  assign wr_hi   = wr_en && (addr == ADDR_HI);
  assign wr_ctrl = wr_en && (addr == ADDR_CTRL);
  assign wr_dpm  = wr_en && (addr == ADDR_DPM);

  // Read mux built from pre-edge values, so a simultaneous write still
  // returns the old contents.
  logic [31:0] rd_data;
  logic        rd_mapped;

  always_comb begin
    rd_data   = 32'b0;
    rd_mapped = 1'b1;
    case (addr)
      ADDR_LO:     rd_data = {16'b0, staging_q};
      ADDR_HI:     rd_data = {12'b0, display_q};
      ADDR_CTRL:   rd_data = {30'b0, lzb_q, (state_q == ST_SCAN)};
      ADDR_DPM:    rd_data = {27'b0, dpm_q};
      ADDR_STATUS: rd_data = {29'b0, idx_q};
      default:     rd_mapped = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration and value registers
  // --------------------------------------------------------------------------
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      staging_q <= 16'b0;
      display_q <= 20'b0;
      lzb_q     <= 1'b0;
      dpm_q     <= 5'b0;
    end else begin
      if (wr_lo) begin
        staging_q <= d_in;
      end
      // The HI write publishes all five digits at once, so the display never
      // shows a half-updated value.
      if (wr_hi) begin
        display_q <= {d_in[3:0], staging_q};
      end
      if (wr_ctrl) begin
        lzb_q <= d_in[1];
      end
      if (wr_dpm) begin
        dpm_q <= d_in[4:0];
      end
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      d_out <= 32'b0;
    end else if (rd_en && rd_mapped) begin
      d_out <= rd_data;
    end
  end

  // --------------------------------------------------------------------------
  // Scan FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan FSM: next state. The enable bit of CTRL is the state itself.
  always_comb begin
    state_d = state_q;
    if (wr_ctrl) begin
      state_d = d_in[0] ? ST_SCAN : ST_OFF;
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler and digit index
  // --------------------------------------------------------------------------
  // Counters follow the pre-edge state: the edge that enables scanning still
  // clears them, so the first lit digit is always idx 0 for a full period.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= 16'b0;
      idx_q   <= 3'b0;
    end else if (state_q == ST_OFF) begin
      presc_q <= 16'b0;
      idx_q   <= 3'b0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= 16'b0;
      idx_q   <= (idx_q == IDX_LAST) ? 3'b0 : idx_q + 3'd1;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Digit selection, leading-zero detection and segment decode
  // --------------------------------------------------------------------------
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // non-BCD nibble shows a dash
    endcase
    return s;
  endfunction

  logic [3:0] cur_nib;

  always_comb begin
    case (idx_q)
      3'd0:    cur_nib = display_q[3:0];
      3'd1:    cur_nib = display_q[7:4];
      3'd2:    cur_nib = display_q[11:8];
      3'd3:    cur_nib = display_q[15:12];
      3'd4:    cur_nib = display_q[19:16];
      default: cur_nib = 4'd0;
    endcase
  end

  // lead_zero[k] is set when digit k and every digit above it are zero.
  // Digit 0 is excluded so a zero value still shows a single '0'.
  logic [4:0] lead_zero;
  logic [4:0] blank_mask;
  logic       blank_cur;

  always_comb begin
    lead_zero    = 5'b0;
    lead_zero[4] = (display_q[19:16] == 4'd0);
    lead_zero[3] = lead_zero[4] && (display_q[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (display_q[11:8]  == 4'd0);
    lead_zero[1] = lead_zero[2] && (display_q[7:4]   == 4'd0);
  end

  assign blank_mask = lzb_q ? lead_zero : 5'b0;

  always_comb begin
    case (idx_q)
      3'd0:    blank_cur = blank_mask[0];
      3'd1:    blank_cur = blank_mask[1];
      3'd2:    blank_cur = blank_mask[2];
      3'd3:    blank_cur = blank_mask[3];
      3'd4:    blank_cur = blank_mask[4];
      default: blank_cur = 1'b1;
    endcase
  end

  logic dpm_cur;

  always_comb begin
    case (idx_q)
      3'd0:    dpm_cur = dpm_q[0];
      3'd1:    dpm_cur = dpm_q[1];
      3'd2:    dpm_cur = dpm_q[2];
      3'd3:    dpm_cur = dpm_q[3];
      3'd4:    dpm_cur = dpm_q[4];
      default: dpm_cur = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Scan FSM: outputs (next values of the registered display pins)
  // --------------------------------------------------------------------------
  logic [4:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == ST_SCAN && !blank_cur) begin
      an_d  = ~(5'b00001 << idx_q);
      seg_d = bcd_to_seg(cur_nib);
      dp_d  = ~dpm_cur;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_peripheral_bcd7seg.sv
module tb_peripheral_bcd7seg;

  localparam int DIV = 4;

  localparam logic [4:0] A_LO     = 5'h04;
  localparam logic [4:0] A_HI     = 5'h08;
  localparam logic [4:0] A_CTRL   = 5'h0C;
  localparam logic [4:0] A_DPM    = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] d_in = 16'h0;
  logic        cs = 1'b0;
  logic [4:0]  addr = 5'h0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] d_out;
  logic [4:0]  an;
  logic [6:0]  seg;
  logic        dp;

  peripheral_bcd7seg #(.CLK_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running want=finished");
    $fatal(1);
  end

  typedef struct packed {
    logic [4:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       seg_chk;
  } disp_t;

  disp_t       disp_q[$];
  logic [31:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Expected display pins for one full frame, DIV samples per digit.
  function automatic void push_frame(input logic [19:0] value, input logic [4:0] dpm,
                                     input logic lzb);
    for (int d = 0; d < 5; d++) begin
      disp_t      e;
      logic [19:0] upper;
      logic       blank;
      upper = value >> (4 * d);
      blank = lzb && (d != 0) && (upper == 20'h0);
      if (blank) begin
        e.an = 5'b11111; e.seg = 7'h7F; e.dp = 1'b1; e.seg_chk = 1'b0;
      end else begin
        e.an = ~(5'b00001 << d);
        e.seg = seg_ref(value[4*d +: 4]);
        e.dp = ~dpm[d];
        e.seg_chk = 1'b1;
      end
      for (int c = 0; c < DIV; c++) disp_q.push_back(e);
    end
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [15:0] v);
    @(posedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(posedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
    @(posedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk);
    cs = 1'b0; rd = 1'b0;
    v = d_out;
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    repeat (2) @(posedge clk);
    vectors++;
    if (an !== 5'b11111) begin miscompares++; $display("FAIL reset_an got=%b want=11111", an); end
    vectors++;
    if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg got=%h want=7f", seg); end
    vectors++;
    if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp got=%b want=1", dp); end
    vectors++;
    if (d_out !== 32'h0) begin miscompares++; $display("FAIL reset_dout got=%h want=0", d_out); end
    reset = 1'b0;
    rd_q.push_back(32'h0);
    bus_read(A_STATUS, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_status got=%h want=%h", got, exp); end
  endtask

  task automatic test_scan;
    logic [31:0] got, exp;
    disp_t e;
    bus_write(A_CTRL, 16'h0);
    bus_write(A_LO, 16'h4321);
    bus_write(A_HI, 16'h0005);
    rd_q.push_back(32'h0000_4321);
    bus_read(A_LO, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL scan_rd_lo got=%h want=%h", got, exp); end
    rd_q.push_back(32'h0005_4321);
    bus_read(A_HI, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL scan_rd_hi got=%h want=%h", got, exp); end
    push_frame(20'h54321, 5'b00000, 1'b0);
    push_frame(20'h54321, 5'b00000, 1'b0);
    bus_write(A_CTRL, 16'h0001);
    while (disp_q.size() > 0) begin
      @(posedge clk);
      e = disp_q.pop_front();
      vectors++;
      if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
        miscompares++;
        $display("FAIL scan_pins got=%b/%h/%b want=%b/%h/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_lzb;
    logic [31:0] got, exp;
    disp_t e;
    bus_write(A_CTRL, 16'h0);
    bus_write(A_LO, 16'h0042);
    bus_write(A_HI, 16'h0000);
    push_frame(20'h00042, 5'b00000, 1'b1);
    bus_write(A_CTRL, 16'h0003);
    while (disp_q.size() > 0) begin
      @(posedge clk);
      e = disp_q.pop_front();
      vectors++;
      if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
        miscompares++;
        $display("FAIL lzb_42 got=%b/%h/%b want=%b/%h/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
    end
    rd_q.push_back(32'h3);
    bus_read(A_CTRL, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL lzb_rd_ctrl got=%h want=%h", got, exp); end
    bus_write(A_CTRL, 16'h0);
    bus_write(A_LO, 16'h0000);
    bus_write(A_HI, 16'h0000);
    push_frame(20'h00000, 5'b00000, 1'b1);
    bus_write(A_CTRL, 16'h0003);
    while (disp_q.size() > 0) begin
      @(posedge clk);
      e = disp_q.pop_front();
      vectors++;
      if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
        miscompares++;
        $display("FAIL lzb_zero got=%b/%h/%b want=%b/%h/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_staging;
    logic [31:0] got, exp;
    disp_t e;
    bus_write(A_CTRL, 16'h0);
    bus_write(A_LO, 16'h4321);
    bus_write(A_HI, 16'h0005);
    bus_write(A_LO, 16'h9A00);
    rd_q.push_back(32'h0005_4321);
    bus_read(A_HI, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL stage_hold got=%h want=%h", got, exp); end
    rd_q.push_back(32'h0000_9A00);
    bus_read(A_LO, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL stage_lo got=%h want=%h", got, exp); end
    bus_write(A_HI, 16'h000F);
    rd_q.push_back(32'h000F_9A00);
    bus_read(A_HI, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL stage_commit got=%h want=%h", got, exp); end
    push_frame(20'hF9A00, 5'b00000, 1'b0);
    bus_write(A_CTRL, 16'h0001);
    while (disp_q.size() > 0) begin
      @(posedge clk);
      e = disp_q.pop_front();
      vectors++;
      if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
        miscompares++;
        $display("FAIL stage_dash got=%b/%h/%b want=%b/%h/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_dp;
    logic [31:0] got, exp;
    disp_t e;
    bus_write(A_CTRL, 16'h0);
    bus_write(A_LO, 16'h4321);
    bus_write(A_HI, 16'h0005);
    bus_write(A_DPM, 16'h0004);
    rd_q.push_back(32'h4);
    bus_read(A_DPM, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL dp_rd got=%h want=%h", got, exp); end
    push_frame(20'h54321, 5'b00100, 1'b0);
    bus_write(A_CTRL, 16'h0001);
    while (disp_q.size() > 0) begin
      @(posedge clk);
      e = disp_q.pop_front();
      vectors++;
      if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
        miscompares++;
        $display("FAIL dp_idx2 got=%b/%h/%b want=%b/%h/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
    end
    bus_write(A_CTRL, 16'h0);
    bus_write(A_LO, 16'h0000);
    bus_write(A_HI, 16'h0000);
    push_frame(20'h00000, 5'b00100, 1'b1);
    bus_write(A_CTRL, 16'h0003);
    while (disp_q.size() > 0) begin
      @(posedge clk);
      e = disp_q.pop_front();
      vectors++;
      if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
        miscompares++;
        $display("FAIL dp_blank got=%b/%h/%b want=%b/%h/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  task automatic test_rw_same;
    logic [31:0] got, exp;
    bus_write(A_CTRL, 16'h0);
    rd_q.push_back(32'h4);
    @(posedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = A_DPM; d_in = 16'h001F;
    @(posedge clk);
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    got = d_out;
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rw_old_dpm got=%h want=%h", got, exp); end
    rd_q.push_back(32'h1F);
    bus_read(A_DPM, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rw_new_dpm got=%h want=%h", got, exp); end
    rd_q.push_back(32'h0);
    @(posedge clk);
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = A_CTRL; d_in = 16'h0002;
    @(posedge clk);
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    got = d_out;
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rw_old_ctrl got=%h want=%h", got, exp); end
    rd_q.push_back(32'h2);
    bus_read(A_CTRL, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rw_new_ctrl got=%h want=%h", got, exp); end
  endtask

  task automatic test_unmapped;
    logic [31:0] got, exp;
    bus_write(A_CTRL, 16'h0);
    bus_write(A_STATUS, 16'hFFFF);
    bus_write(5'h00, 16'hFFFF);
    bus_write(5'h18, 16'hFFFF);
    @(posedge clk);
    cs = 1'b0; wr = 1'b1; addr = A_LO; d_in = 16'h1234;
    @(posedge clk);
    wr = 1'b0;
    rd_q.push_back(32'h0);
    bus_read(A_STATUS, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL unm_status got=%h want=%h", got, exp); end
    rd_q.push_back(32'h0);
    bus_read(A_LO, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL unm_lo got=%h want=%h", got, exp); end
    rd_q.push_back(32'h1F);
    bus_read(A_DPM, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL unm_dpm got=%h want=%h", got, exp); end
    rd_q.push_back(32'h1F);
    bus_read(5'h1C, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL unm_hold got=%h want=%h", got, exp); end
    rd_q.push_back(32'h1F);
    @(posedge clk);
    cs = 1'b0; rd = 1'b1; addr = A_LO;
    @(posedge clk);
    rd = 1'b0;
    got = d_out;
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL unm_nocs got=%h want=%h", got, exp); end
  endtask

  task automatic test_async_reset;
    logic [31:0] got, exp;
    logic        found;
    disp_t       e;
    bus_write(A_CTRL, 16'h0);
    bus_write(A_DPM, 16'h0000);
    bus_write(A_LO, 16'h4321);
    bus_write(A_HI, 16'h0005);
    rd_q.push_back(32'h0005_4321);
    bus_read(A_HI, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ar_rd_hi got=%h want=%h", got, exp); end
    bus_write(A_CTRL, 16'h0001);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      if (an === 5'b10111) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL ar_wait_digit3 got=timeout want=an 10111"); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (an !== 5'b11111) begin miscompares++; $display("FAIL ar_an got=%b want=11111", an); end
    vectors++;
    if (seg !== 7'h7F) begin miscompares++; $display("FAIL ar_seg got=%h want=7f", seg); end
    vectors++;
    if (dp !== 1'b1) begin miscompares++; $display("FAIL ar_dp got=%b want=1", dp); end
    vectors++;
    if (d_out !== 32'h0) begin miscompares++; $display("FAIL ar_dout got=%h want=0", d_out); end
    @(posedge clk);
    reset = 1'b0;
    e.an = 5'b11111; e.seg = 7'h7F; e.dp = 1'b1; e.seg_chk = 1'b1;
    for (int i = 0; i < 6 * DIV; i++) disp_q.push_back(e);
    while (disp_q.size() > 0) begin
      @(posedge clk);
      e = disp_q.pop_front();
      vectors++;
      if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
        miscompares++;
        $display("FAIL ar_stays_off got=%b/%h/%b want=%b/%h/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
    end
    rd_q.push_back(32'h0);
    bus_read(A_CTRL, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ar_ctrl got=%h want=%h", got, exp); end
    rd_q.push_back(32'h0);
    bus_read(A_HI, got);
    exp = rd_q.pop_front();
    vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ar_display got=%h want=%h", got, exp); end
    push_frame(20'h00000, 5'b00000, 1'b0);
    bus_write(A_CTRL, 16'h0001);
    while (disp_q.size() > 0) begin
      @(posedge clk);
      e = disp_q.pop_front();
      vectors++;
      if (an !== e.an || dp !== e.dp || (e.seg_chk && seg !== e.seg)) begin
        miscompares++;
        $display("FAIL ar_rescan got=%b/%h/%b want=%b/%h/%b", an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lzb();
    test_staging();
    test_dp();
    test_rw_same();
    test_unmapped();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
